sum_threshold_node: RTL

//  Downstream consumer of PE partial-sum packets in the SNN NoC. It accumulates NUM_PSUM

---
 rtl/sum_threshold_node.sv | 134 +++++++++++++
 1 files changed

// File: rtl/sum_threshold_node.sv
// Sum/threshold node: integrates NUM_PSUM psum packets per timestep into a saturating membrane
// potential and emits one spike packet per timestep. Define SNN_LEAK_EN to enable the shift leak.
module sum_threshold_node #(
  parameter int unsigned WIDTH         = 35,
  parameter logic [3:0]  ST_ADDR       = 4'b0011,
  parameter logic [3:0]  OUT_ADDR      = 4'b1111,
  parameter int unsigned NUM_PSUM      = 3,
  parameter int unsigned NUM_TIMESTEPS = 10,
  parameter int unsigned MP_WIDTH      = 12,
  parameter int unsigned THRESHOLD     = 64,
  parameter int unsigned LEAK_SHIFT    = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [WIDTH-1:0]    in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [WIDTH-1:0]    out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [MP_WIDTH-1:0] mp_dbg
);

  localparam int unsigned AccW = 8 + $clog2(NUM_PSUM + 1);
  localparam int unsigned CntW = $clog2(NUM_PSUM + 1);
  localparam int unsigned SumW = ((MP_WIDTH > AccW) ? MP_WIDTH : AccW) + 1;

  localparam logic [MP_WIDTH-1:0] MpMax   = '1;
  localparam logic [MP_WIDTH-1:0] Thr     = MP_WIDTH'(THRESHOLD);
  localparam logic [CntW-1:0]     LastCnt = CntW'(NUM_PSUM - 1);
  localparam logic [7:0]          LastTs  = 8'(NUM_TIMESTEPS - 1);

  typedef enum logic [1:0] {StAccum, StInteg, StSend} state_e;

  state_e               state_q;
  logic                 in_ready_q;
  logic                 out_valid_q;
  logic [WIDTH-1:0]     out_data_q;
  logic [AccW-1:0]      acc_q;
  logic [CntW-1:0]      cnt_q;
  logic [7:0]           ts_q;
  logic [MP_WIDTH-1:0]  mp_q;

  logic [3:0]           pkt_dst;
  logic [7:0]           pkt_psum;
  logic [MP_WIDTH-1:0]  mp_base;
  logic [SumW-1:0]      mp_sum;
  logic [MP_WIDTH-1:0]  mp_sat;
  logic                 fire;
  logic [MP_WIDTH-1:0]  mp_next;
  logic [34:0]          spike_pkt;
  logic                 unused_bits;

  assign pkt_dst  = in_data[30:27];
  assign pkt_psum = in_data[7:0];

`ifdef SNN_LEAK_EN
  assign mp_base     = mp_q - (mp_q >> LEAK_SHIFT);
  assign unused_bits = ^{in_data[34:31], in_data[26:8]};
`else
  assign mp_base     = mp_q;
  assign unused_bits = ^{in_data[34:31], in_data[26:8], LEAK_SHIFT};
`endif

  // Integrate, clamp before the compare so the potential never wraps, then subtractive reset.
  always_comb begin
    mp_sum  = SumW'(mp_base) + SumW'(acc_q);
    mp_sat  = (mp_sum > SumW'(MpMax)) ? MpMax : mp_sum[MP_WIDTH-1:0];
    fire    = (mp_sat >= Thr);
    mp_next = fire ? (mp_sat - Thr) : mp_sat;
  end

  assign spike_pkt = {ST_ADDR, OUT_ADDR, 3'b010, ts_q, 15'b0, fire};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StAccum;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      ts_q        <= '0;
      mp_q        <= '0;
    end else begin
      unique case (state_q)
        StAccum: begin
          in_ready_q <= 1'b1;
          // Packets for other nodes are consumed by the handshake but leave no trace.
          if (in_valid && in_ready_q && (pkt_dst == ST_ADDR)) begin
            acc_q <= acc_q + AccW'(pkt_psum);
            if (cnt_q == LastCnt) begin
              cnt_q      <= '0;
              in_ready_q <= 1'b0;
              state_q    <= StInteg;
            end else begin
              cnt_q <= cnt_q + CntW'(1);
            end
          end
        end
        StInteg: begin
          mp_q        <= mp_next;
          acc_q       <= '0;
          out_data_q  <= WIDTH'(spike_pkt);
          out_valid_q <= 1'b1;
          state_q     <= StSend;
        end
        StSend: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= StAccum;
            if (ts_q == LastTs) begin
              ts_q <= '0;
              mp_q <= '0;
            end else begin
              ts_q <= ts_q + 8'd1;
            end
          end
        end
        default: begin
          state_q    <= StAccum;
          in_ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign mp_dbg    = mp_q;

endmodule
